dio_in_capture: RTL
===================

Name: dio_in_capture

Overview:
- Input-side companion to the DIO tristate pad block. Consumes the eight raw pad readbacks (DIO_0_in..DIO_7_in, bundled as dio_in) and the same direction mask (state).
- Per line it synchronises, glitch-filters, detects edges, raises single-cycle event pulses and sticky flags, and keeps saturating event counters.
- Feeds trigger logic and an AXI register bank (counter readout mux).

Parameters:
FILTER_WIDTH, 8, width of per-line glitch-filter counter and filter_len
COUNT_WIDTH, 32, width of each per-line event counter

Ports:
clk  input  1  system clock
aresetn  input  1  asynchronous active-low reset
dio_in  input  8  raw pad readbacks, asynchronous to clk
state  input  8  direction mask, same encoding as pad block: 1=input, 0=output
filter_len  input  FILTER_WIDTH  required stable cycles minus one (0 = no filtering)
rise_en  input  8  per-line rising-edge event enable
fall_en  input  8  per-line falling-edge event enable
flag_clear  input  8  per-line sticky-flag clear, level-sampled each cycle
count_clear  input  8  per-line counter clear, level-sampled each cycle
count_sel  input  3  counter readout select
value_filt  output  8  filtered line levels
event_pulse  output  8  one-cycle event strobes
event_flag  output  8  sticky event flags
count_out  output  COUNT_WIDTH  selected counter value, registered

Behaviour:
- Reset (aresetn low, asynchronous): all registers 0. This covers synchronisers, filter counters, value_filt, event_pulse, event_flag, all counters and count_out.
- Sync: 2-FF synchroniser per line; sync[i] is the second stage.
- Filter, per line:
  - sync[i]==value_filt[i]: fcnt[i] <= 0.
  - Otherwise, if fcnt[i] >= filter_len: value_filt[i] <= sync[i] and fcnt[i] <= 0; else fcnt[i] increments.
  - A change therefore needs filter_len+1 consecutive differing cycles. Shorter pulses are discarded with no output change.
  - The `>=` compare means lowering filter_len mid-count takes effect on the next cycle. fcnt never wraps.
  - Latency from dio_in edge to value_filt: 3+filter_len cycles.
- Filtering runs regardless of state, so value_filt reflects the driven level on output lines.
- Edge detect: a registered copy of value_filt gives rise = filt & ~prev and fall = ~filt & prev.
  - event_pulse[i] <= state[i] & ((rise & rise_en[i]) | (fall & fall_en[i])). It is a one-cycle pulse, one cycle after the value_filt change.
  - Latency from dio_in edge to event_pulse: 4+filter_len cycles.
- Output lines (state[i]=0) never produce events. Toggling state has no effect on value_filt.
- Post-reset: a line already high at reset release produces a rising event once filtered, if rise_en is set. Software clears it after enabling.
- Sticky flag: event_pulse[i] sets event_flag[i]; flag_clear[i] clears it. If both occur in the same cycle, the set wins and the flag remains 1.
- Counters: an event_pulse[i] increments cnt[i], saturating at 2^COUNT_WIDTH-1 with no wrap.
  - count_clear[i] loads 0.
  - Clear and event in the same cycle loads 1, so no event is lost.
- count_out <= cnt[count_sel], one-cycle latency from count_sel or counter change.
- Reset asserted mid-operation: everything returns to 0 immediately. No events are generated during reset or on the reset release cycle itself.

Test Plan:
1. filter_len=0, state=FF, rise_en=01. Raise dio_in[0] at cycle 0. Expect value_filt[0]=1 at cycle 3, event_pulse[0]=1 for cycle 4 only, event_flag[0]=1 from cycle 5, count_out=1 with count_sel=0.
2. filter_len=4, state=FF. Apply a 4-cycle high glitch on dio_in[3]: no change to value_filt[3] and no event. Then a 5-cycle high pulse: value_filt[3] rises at cycle 7 relative to the pulse start.
3. state=FE, rise_en=fall_en=FF. Toggle dio_in[0] and dio_in[1]. value_filt follows both lines, but events and counters move only for line 1; line 0 stays 0.
4. Drive flag_clear[2] high on the same cycle as event_pulse[2]: event_flag[2] stays 1. Clear it on a later cycle: it goes to 0.
5. COUNT_WIDTH=4. Apply 17 events on line 5: count_out saturates at 15. Assert count_clear[5] together with an event: count becomes 1.
6. Assert aresetn low mid-filter, with fcnt partially counted and event_flag set: all outputs read 0 immediately. After release with the input still high, one filtered rising event occurs at the expected latency.

Source files
------------

// File: rtl/dio_in_capture.sv
// Input-side capture for the eight DIO pads: synchronise, glitch-filter, edge-detect,
// and keep per-line event pulses, sticky flags and saturating counters.
module dio_in_capture #(
   parameter int unsigned FILTER_WIDTH = 8,
   parameter int unsigned COUNT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [7:0]              dio_in,
   input  logic [7:0]              state,
   input  logic [FILTER_WIDTH-1:0] filter_len,
   input  logic [7:0]              rise_en,
   input  logic [7:0]              fall_en,
   input  logic [7:0]              flag_clear,
   input  logic [7:0]              count_clear,
   input  logic [2:0]              count_sel,
   output logic [7:0]              value_filt,
   output logic [7:0]              event_pulse,
   output logic [7:0]              event_flag,
   output logic [COUNT_WIDTH-1:0]  count_out
);

   localparam logic [FILTER_WIDTH-1:0] FCNT_ONE = FILTER_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0]  CNT_ONE  = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0]  CNT_MAX  = {COUNT_WIDTH{1'b1}};

   logic [7:0]                    sync1_q, sync2_q;
   logic [7:0][FILTER_WIDTH-1:0]  fcnt_q, fcnt_d;
   logic [7:0]                    filt_q, filt_d;
   logic [7:0]                    prev_q;
   logic [7:0]                    pulse_q, pulse_d;
   logic [7:0]                    flag_q, flag_d;
   logic [7:0][COUNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0]        count_out_q, count_out_d;
   logic [7:0]                    rise_s, fall_s;

   always_comb begin
      fcnt_d = fcnt_q;
      filt_d = filt_q;
      for (int i = 0; i < 8; i++) begin
         // The >= compare lets a lowered filter_len take effect immediately and keeps fcnt from wrapping.
         if (sync2_q[i] == filt_q[i]) begin
            fcnt_d[i] = '0;
         end else if (fcnt_q[i] >= filter_len) begin
            filt_d[i] = sync2_q[i];
            fcnt_d[i] = '0;
         end else begin
            fcnt_d[i] = fcnt_q[i] + FCNT_ONE;
         end
      end
   end

   always_comb begin
      rise_s  = filt_q & ~prev_q;
      fall_s  = ~filt_q & prev_q;
      pulse_d = state & ((rise_s & rise_en) | (fall_s & fall_en));
      // Setting has priority over clearing so a coincident event is never lost.
      flag_d  = (flag_q & ~flag_clear) | pulse_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (count_clear[i]) begin
            cnt_d[i] = pulse_q[i] ? CNT_ONE : '0;
         end else if (pulse_q[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
      count_out_d = cnt_q[count_sel];
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         fcnt_q      <= '0;
         filt_q      <= '0;
         prev_q      <= '0;
         pulse_q     <= '0;
         flag_q      <= '0;
         cnt_q       <= '0;
         count_out_q <= '0;
      end else begin
         sync1_q     <= dio_in;
         sync2_q     <= sync1_q;
         fcnt_q      <= fcnt_d;
         filt_q      <= filt_d;
         prev_q      <= filt_q;
         pulse_q     <= pulse_d;
         flag_q      <= flag_d;
         cnt_q       <= cnt_d;
         count_out_q <= count_out_d;
      end
   end

   assign value_filt  = filt_q;
   assign event_pulse = pulse_q;
   assign event_flag  = flag_q;
   assign count_out   = count_out_q;

endmodule
